gpio_in_dev_io: RTL and testbench
=================================

Name: gpio_in_dev_io

Overview:
- Memory-mapped input peripheral on the MIO bus at region d0000000-dfffffff; the read-side counterpart to the write-only LED and 7-seg GPIO devices.
- Synchronises the debounced switches and buttons, captures rising edges into sticky flags, and counts button events.
- Answers CPU bus reads and writes with a 4-phase req/ready handshake. Its ready output is ANDed into the CPU's MIO_ready.

Parameters:
- SW_W, 8, switch input width
- BTN_W, 5, button input width
- CNT_W, 16, event counter width (must be 8..31)

Ports:
- clk  input  1  peripheral clock (clk_io domain)
- rst  input  1  asynchronous reset, active-low
- GPIOd0000000_sel  input  1  bus request; held until ready seen
- GPIOd0000000_we  input  1  1 = write, 0 = read; valid with sel
- addr  input  2  register select (bus addr[3:2])
- data_in  input  32  write data from CPU
- data_out  output  32  read data to CPU
- ready  output  1  handshake acknowledge
- SW  input  SW_W  debounced switches
- BTN  input  BTN_W  debounced buttons
- irq  output  1  level: any enabled flag set

Behaviour:
- Reset (rst=0, asynchronous), all registers clear:
  - data_out=0, ready=0, irq=0
  - flags=0, mask=0, count=0, ovf=0
  - synchroniser stages=0
  - FSM=IDLE
- Input path: 2-flop synchroniser on {BTN,SW}, then a third "previous" flop. rise = sync & ~prev, per bit.
- Register map (32-bit, zero-extended):
  - addr 0 STATUS (RO): {BTN_sync, SW_sync}, buttons above switches.
  - addr 1 FLAGS: sticky rising-edge bits, same layout as STATUS. A read returns the flags and clears the bits returned. A write of 1s clears the selected bits.
  - addr 2 MASK (RW): irq enable, same layout.
  - addr 3 COUNT: bit 31 = ovf, low CNT_W bits = count of button rising edges. A write of any value zeroes count and ovf.
- Counting:
  - Add popcount(BTN rise) per cycle.
  - On wrap past 2^CNT_W-1, the count keeps its modulo value and ovf is set sticky.
- FSM, 3 states:
  - IDLE: sel=1 → ACCESS. Latch addr, we and data_in.
  - ACCESS: one cycle. Perform the read (load data_out) or the write, then → DONE.
  - DONE: ready=1. Stay while sel=1; sel=0 → IDLE and ready=0 the next cycle.
- Latency and handshake:
  - Latency: ready rises 2 clocks after sel is sampled high.
  - data_out is stable whenever ready=1. It holds its last value otherwise.
  - A new access requires sel to drop through IDLE. Back-to-back sel without a deassert is ignored until sel=0.
- Simultaneous events:
  - Flag set and read-clear/write-clear in the same cycle: set wins, so the new edge is not lost.
  - Count write and edge in the same cycle: count becomes 0, and the edge is dropped.
- Write to STATUS: ignored, but the handshake completes.
- Write to MASK: low SW_W+BTN_W bits are stored; upper bits are ignored.
- irq = |(flags & mask), registered, one cycle after the flag update.
- Reset mid-transaction: FSM returns to IDLE and ready drops immediately. The master must re-issue the access.

Decomposition:
- Shared package (gpio_in_pkg) holds:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Register offset constants: REG_STATUS, REG_FLAGS, REG_MASK, REG_COUNT.
- Sub-module edge_sync_det (width-parameterised) provides the synchroniser, prev flop and rise vector. It is reused for each input group.
- The popcount is an inline function.

Test Plan:
- Reset: rst=0 for 3 clocks with sel=1 → ready=0, data_out=0, irq=0. After release, a STATUS read shows the current SW/BTN.
- Handshake latency: SW=8'hA5, BTN=0, read addr 0 → ready high exactly 2 clocks after sel. data_out=32'h000000A5. ready falls 1 clock after sel drops.
- Edge and read-clear:
  - Pulse BTN[0] for 1 clock, then read FLAGS → data_out=32'h00000100.
  - Second FLAGS read → 0.
  - Pulse BTN[0] in the same cycle as the read's ACCESS → the flag remains set afterwards.
- irq: write MASK=32'h100, pulse BTN[0] → irq=1 within 4 clocks. Write FLAGS=32'h100 → irq=0.
- Counter wrap with CNT_W=8:
  - 255 single-button pulses, then 1 more → COUNT reads 32'h80000000.
  - Write COUNT → reads 0.
  - Two buttons rising in the same cycle → count increments by 2.
- Reset mid-access: assert rst in DONE → ready=0 asynchronously. After release, a new read completes normally.

Source files
------------

// File: rtl/gpio_in_pkg.sv
// Shared encodings for the MIO input GPIO peripheral: FSM states and register offsets.
package gpio_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } gpio_state_e;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_FLAGS  = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

endpackage

// File: rtl/edge_sync_det.sv
// Two-flop synchroniser plus a "previous" flop; rise_o pulses for one cycle per 0->1 transition.
module edge_sync_det #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/gpio_in_dev_io.sv
// MIO input peripheral: synchronised switches/buttons, sticky edge flags, masked irq and a
// button event counter behind a 4-phase sel/ready handshake (IDLE -> ACCESS -> DONE).
module gpio_in_dev_io
  import gpio_in_pkg::*;
#(
  parameter int SW_W  = 8,
  parameter int BTN_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             GPIOd0000000_sel,
  input  logic             GPIOd0000000_we,
  input  logic [1:0]       addr,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             ready,
  input  logic [SW_W-1:0]  SW,
  input  logic [BTN_W-1:0] BTN,
  output logic             irq,
  output logic [1:0]       state_dbg
);

  localparam int N = SW_W + BTN_W;

  function automatic logic [CNT_W:0] popcount(input logic [BTN_W-1:0] v);
    logic [CNT_W:0] c;
    c = '0;
    for (int i = 0; i < BTN_W; i++) c = c + {{CNT_W{1'b0}}, v[i]};
    return c;
  endfunction

  logic [SW_W-1:0]  sw_sync, sw_rise;
  logic [BTN_W-1:0] btn_sync, btn_rise;

  edge_sync_det #(.W(SW_W)) u_sw_sync (
    .clk(clk), .rst_n(rst), .d_i(SW), .sync_o(sw_sync), .rise_o(sw_rise)
  );

  edge_sync_det #(.W(BTN_W)) u_btn_sync (
    .clk(clk), .rst_n(rst), .d_i(BTN), .sync_o(btn_sync), .rise_o(btn_rise)
  );

  gpio_state_e      state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic             we_q, we_d;
  logic [N-1:0]     wdata_q, wdata_d;
  logic [31:0]      data_out_q, data_out_d;
  logic             ready_q, ready_d;
  logic             irq_q, irq_d;
  logic [N-1:0]     flags_q, flags_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             rd_en, wr_en;
  logic [31:0]      rd_data;
  logic [N-1:0]     clr;
  logic [CNT_W:0]   sum;

  // Only the low N data bits ever reach a register; the rest is intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^data_in[31:N];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (GPIOd0000000_sel) begin
          state_d = ST_ACCESS;
          addr_d  = addr;
          we_d    = GPIOd0000000_we;
          wdata_d = data_in[N-1:0];
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   if (!GPIOd0000000_sel) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_DONE);
  end

  assign rd_en = (state_q == ST_ACCESS) && !we_q;
  assign wr_en = (state_q == ST_ACCESS) && we_q;

  always_comb begin
    rd_data = '0;
    case (addr_q)
      REG_STATUS: rd_data[N-1:0] = {btn_sync, sw_sync};
      REG_FLAGS:  rd_data[N-1:0] = flags_q;
      REG_MASK:   rd_data[N-1:0] = mask_q;
      default: begin
        rd_data[CNT_W-1:0] = cnt_q;
        rd_data[31]        = ovf_q;
      end
    endcase
    data_out_d = rd_en ? rd_data : data_out_q;

    // A new edge in the clearing cycle is OR-ed in after the clear, so it survives.
    clr = '0;
    if (rd_en && addr_q == REG_FLAGS) clr = flags_q;
    if (wr_en && addr_q == REG_FLAGS) clr = wdata_q;
    flags_d = (flags_q & ~clr) | {btn_rise, sw_rise};

    mask_d = (wr_en && addr_q == REG_MASK) ? wdata_q : mask_q;

    sum = {1'b0, cnt_q} + popcount(btn_rise);
    if (wr_en && addr_q == REG_COUNT) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      cnt_d = sum[CNT_W-1:0];
      ovf_d = ovf_q | sum[CNT_W];
    end

    irq_d = |(flags_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      irq_q      <= 1'b0;
      flags_q    <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      irq_q      <= irq_d;
      flags_q    <= flags_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign irq       = irq_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gpio_in_dev_io.sv
// Directed bench for gpio_in_dev_io with an 8-bit counter so the wrap is reachable.
module tb_gpio_in_dev_io;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic [7:0]  sw;
  logic [4:0]  btn;
  logic        irq;
  logic [1:0]  state_dbg;
  logic [31:0] r;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  gpio_in_dev_io #(.SW_W(8), .BTN_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .GPIOd0000000_sel(sel), .GPIOd0000000_we(we),
    .addr(addr), .data_in(data_in), .data_out(data_out), .ready(ready),
    .SW(sw), .BTN(btn), .irq(irq), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input logic lvl, input string tag);
    int k;
    k = 0;
    while (ready !== lvl && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (ready !== lvl) chk(tag, {31'b0, ready}, {31'b0, lvl});
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    @(negedge clk);
    sel = 1'b1; we = w; addr = a; data_in = d;
    @(negedge clk);
    wait_ready(1'b1, "bus_ready_timeout");
    rd  = data_out;
    sel = 1'b0;
    wait_ready(1'b0, "bus_release_timeout");
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'h0, v);
    chk(tag, v, exp);
  endtask

  task automatic pulse(input logic [4:0] v);
    btn = v;
    tick(1);
    btn = '0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset held with sel asserted: nothing may respond.
    rst = 1'b0; sel = 1'b1; we = 1'b0; addr = 2'd0; data_in = '0;
    sw = 8'h3C; btn = '0;
    tick(3);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_state", {30'b0, state_dbg}, 32'd0);
    sel = 1'b0;
    rst = 1'b1;
    tick(3);
    rd_chk("status_after_reset", 2'd0, 32'h0000003C);

    // Latency: ready one clock late is still low, two clocks after sel it is high.
    sw = 8'hA5;
    tick(3);
    sel = 1'b1; we = 1'b0; addr = 2'd0;
    tick(1);
    chk("lat_1clk_ready", {31'b0, ready}, 32'd0);
    chk("lat_1clk_state", {30'b0, state_dbg}, 32'd1);
    tick(1);
    chk("lat_2clk_ready", {31'b0, ready}, 32'd1);
    chk("lat_data", data_out, 32'h000000A5);
    sel = 1'b0;
    tick(1);
    chk("lat_ready_fall", {31'b0, ready}, 32'd0);
    chk("lat_data_hold", data_out, 32'h000000A5);

    // Switch edges so far: 00->3C after reset, 3C->A5 gives 0x81.
    rd_chk("flags_sw_edges", 2'd1, 32'h000000BD);

    pulse(5'b00001);
    tick(3);
    rd_chk("flags_btn0", 2'd1, 32'h00000100);
    rd_chk("flags_read_clear", 2'd1, 32'h00000000);

    // Flag already set, then a new edge lands on the read's ACCESS cycle.
    pulse(5'b00001);
    tick(3);
    btn = 5'b00001;
    tick(1);
    btn = '0; sel = 1'b1; we = 1'b0; addr = 2'd1;
    tick(1);
    wait_ready(1'b1, "samecyc_ready_timeout");
    chk("samecyc_read", data_out, 32'h00000100);
    sel = 1'b0;
    wait_ready(1'b0, "samecyc_release_timeout");
    rd_chk("samecyc_flag_kept", 2'd1, 32'h00000100);
    rd_chk("samecyc_flag_clr", 2'd1, 32'h00000000);

    // irq path
    bus(1'b1, 2'd2, 32'h00000100, r);
    chk("irq_before_edge", {31'b0, irq}, 32'd0);
    pulse(5'b00001);
    begin
      int k;
      k = 0;
      while (irq !== 1'b1 && k < 4) begin
        tick(1);
        k++;
      end
    end
    chk("irq_set", {31'b0, irq}, 32'd1);
    bus(1'b1, 2'd1, 32'h00000100, r);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    rd_chk("mask_read", 2'd2, 32'h00000100);
    bus(1'b1, 2'd2, 32'hFFFFFFFF, r);
    rd_chk("mask_truncated", 2'd2, 32'h00001FFF);
    bus(1'b1, 2'd0, 32'hFFFFFFFF, r);
    rd_chk("status_write_ignored", 2'd0, 32'h000000A5);
    bus(1'b1, 2'd2, 32'h00000000, r);

    // Counter: four single-button edges so far.
    rd_chk("count_pre", 2'd3, 32'h00000004);
    bus(1'b1, 2'd3, 32'h00001234, r);
    rd_chk("count_zeroed", 2'd3, 32'h00000000);
    for (int i = 0; i < 255; i++) pulse(5'b00001);
    tick(3);
    rd_chk("count_255", 2'd3, 32'h000000FF);
    pulse(5'b00001);
    tick(3);
    rd_chk("count_wrap_ovf", 2'd3, 32'h80000000);
    bus(1'b1, 2'd3, 32'h0, r);
    rd_chk("count_cleared", 2'd3, 32'h00000000);
    pulse(5'b00011);
    tick(3);
    rd_chk("count_two_btn", 2'd3, 32'h00000002);
    pulse(5'b11111);
    tick(3);
    rd_chk("count_five_btn", 2'd3, 32'h00000007);

    // Reset while in DONE: ready must drop without waiting for a clock.
    sel = 1'b1; we = 1'b0; addr = 2'd0;
    tick(2);
    chk("mid_ready_high", {31'b0, ready}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ready}, 32'd0);
    chk("mid_rst_state", {30'b0, state_dbg}, 32'd0);
    chk("mid_rst_data_out", data_out, 32'd0);
    tick(1);
    sel = 1'b0;
    rst = 1'b1;
    tick(3);
    rd_chk("post_reset_status", 2'd0, 32'h000000A5);
    rd_chk("post_reset_count", 2'd3, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
